// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU op encoding, immediate
// formats, the registered decode packet and the ALU-op helper.
package decode_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned RIDX_W  = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [RIDX_W-1:0]  rd;
        logic [INSTR_W-1:0] imm;
        alu_op_e            alu_op;
        logic               rf_we;
        logic               is_load;
        logic               is_store;
        logic               is_branch;
        logic               is_jump;
        logic               illegal;
    } dec_pkt_t;

    // funct3/funct7[5] to ALU op; only register-register ops may select SUB
    function automatic alu_op_e alu_decode(input logic [2:0] funct3,
                                           input logic       alt,
                                           input logic       allow_sub);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (allow_sub && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate extraction by RV32I format, sign-extended from instr[31].
// Ports: instr (instruction word), fmt (immediate format), imm (result).
module decode_stage_imm_gen
    import decode_stage_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  imm_fmt_e           fmt,
    output logic [INSTR_W-1:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage in front of the register file.
// Ports: clk/reset (async, active-high); in_* fetch handshake and instruction;
// rf_rs1/rf_rs2/rf_enable register file read request (combinational);
// out_* registered decode packet with out_valid/out_ready handshake;
// wb_valid/wb_rd writeback clear of the pending-write scoreboard;
// flush squashes the held packet.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_instr,
    input  logic [XLEN-1:0]     in_pc,
    output logic [RIDX_W-1:0]   rf_rs1,
    output logic [RIDX_W-1:0]   rf_rs2,
    output logic                rf_enable,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [RIDX_W-1:0]   out_rd,
    output logic [XLEN-1:0]     out_imm,
    output logic [3:0]          out_alu_op,
    output logic                out_rf_we,
    output logic                out_is_load,
    output logic                out_is_store,
    output logic                out_is_branch,
    output logic                out_is_jump,
    output logic                out_illegal,
    input  logic                wb_valid,
    input  logic [RIDX_W-1:0]   wb_rd,
    input  logic                flush
);

    logic [6:0]        opcode;
    logic [RIDX_W-1:0] dec_rd;
    imm_fmt_e          imm_fmt;
    logic [INSTR_W-1:0] imm_val;
    alu_op_e           dec_alu;
    logic              dec_writes, dec_we, dec_load, dec_store;
    logic              dec_branch, dec_jump, dec_illegal;
    logic              rs1_used, rs2_used;

    dec_pkt_t          pkt_q, pkt_d;
    logic              valid_q;
    logic [NREG-1:0]   pend, pend_next, set_vec, clr_vec, eff_pend;
    logic              rs1_hit, rs2_hit, hazard, accept;

    assign opcode = in_instr[6:0];
    assign dec_rd = in_instr[11:7];
    assign rf_rs1 = in_instr[19:15];
    assign rf_rs2 = in_instr[24:20];

    decode_stage_imm_gen u_imm_gen (
        .instr (in_instr[INSTR_W-1:0]),
        .fmt   (imm_fmt),
        .imm   (imm_val)
    );

    // Opcode decode: format, ALU op, control flags and source usage
    always_comb begin
        imm_fmt     = IMM_NONE;
        dec_alu     = ALU_ADD;
        dec_writes  = 1'b0;
        dec_load    = 1'b0;
        dec_store   = 1'b0;
        dec_branch  = 1'b0;
        dec_jump    = 1'b0;
        dec_illegal = 1'b0;
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm_fmt = IMM_U; dec_alu = ALU_PASSB; dec_writes = 1'b1;
            end
            OPC_AUIPC: begin
                imm_fmt = IMM_U; dec_writes = 1'b1;
            end
            OPC_JAL: begin
                imm_fmt = IMM_J; dec_writes = 1'b1; dec_jump = 1'b1;
            end
            OPC_JALR: begin
                imm_fmt = IMM_I; dec_writes = 1'b1; dec_jump = 1'b1;
                rs1_used = 1'b1;
            end
            OPC_BRANCH: begin
                imm_fmt = IMM_B; dec_alu = ALU_SUB; dec_branch = 1'b1;
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_LOAD: begin
                imm_fmt = IMM_I; dec_writes = 1'b1; dec_load = 1'b1;
                rs1_used = 1'b1;
            end
            OPC_STORE: begin
                imm_fmt = IMM_S; dec_store = 1'b1;
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_OPIMM: begin
                imm_fmt = IMM_I; dec_writes = 1'b1; rs1_used = 1'b1;
                dec_alu = alu_decode(in_instr[14:12], in_instr[30], 1'b0);
            end
            OPC_OP: begin
                dec_writes = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
                dec_alu = alu_decode(in_instr[14:12], in_instr[30], 1'b1);
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_we = dec_writes && (dec_rd != '0);

    // Writeback in the same cycle hides the pending bit from the hazard check
    assign clr_vec  = wb_valid ? (NREG'(1) << wb_rd) : '0;
    assign eff_pend = pend & ~clr_vec;

    // Source conflicts with committed pending writes or the packet still held
    assign rs1_hit = rs1_used && (rf_rs1 != '0) &&
                     (eff_pend[rf_rs1] || (valid_q && pkt_q.rf_we && pkt_q.rd == rf_rs1));
    assign rs2_hit = rs2_used && (rf_rs2 != '0) &&
                     (eff_pend[rf_rs2] || (valid_q && pkt_q.rf_we && pkt_q.rd == rf_rs2));
    assign hazard  = rs1_hit || rs2_hit;

    assign in_ready  = !reset && !flush && !hazard && (!valid_q || out_ready);
    assign rf_enable = in_valid && in_ready;
    assign accept    = rf_enable;

    always_comb begin
        pkt_d           = '0;
        pkt_d.pc        = in_pc[INSTR_W-1:0];
        pkt_d.rd        = dec_rd;
        pkt_d.imm       = imm_val;
        pkt_d.alu_op    = dec_alu;
        pkt_d.rf_we     = dec_we;
        pkt_d.is_load   = dec_load;
        pkt_d.is_store  = dec_store;
        pkt_d.is_branch = dec_branch;
        pkt_d.is_jump   = dec_jump;
        pkt_d.illegal   = dec_illegal;
    end

    // A squashed packet never reaches the scoreboard; set beats clear; x0 never pends
    assign set_vec   = (valid_q && out_ready && pkt_q.rf_we && !flush) ?
                       (NREG'(1) << pkt_q.rd) : '0;
    assign pend_next = ((pend & ~clr_vec) | set_vec) & ~NREG'(1);

    // Packet register and scoreboard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
            pend    <= '0;
        end else begin
            pend <= pend_next;
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                pkt_q   <= pkt_d;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = XLEN'(pkt_q.pc);
    assign out_rd        = pkt_q.rd;
    assign out_imm       = XLEN'(pkt_q.imm);
    assign out_alu_op    = pkt_q.alu_op;
    assign out_rf_we     = pkt_q.rf_we;
    assign out_is_load   = pkt_q.is_load;
    assign out_is_store  = pkt_q.is_store;
    assign out_is_branch = pkt_q.is_branch;
    assign out_is_jump   = pkt_q.is_jump;
    assign out_illegal   = pkt_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expectations.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_rs1, rf_rs2;
    logic        rf_enable;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [3:0]  out_alu_op;
    logic        out_rf_we, out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [31:0] I_ADDI_X5 = 32'h0070_0293; // addi x5,x0,7
    localparam logic [31:0] I_ADD_X6  = 32'h0052_8333; // add  x6,x5,x5
    localparam logic [31:0] I_SUB_X8  = 32'h4020_8433; // sub  x8,x1,x2
    localparam logic [31:0] I_LUI_X10 = 32'h1234_5537; // lui  x10,0x12345
    localparam logic [31:0] I_SW      = 32'hFE71_2E23; // sw   x7,-4(x2)
    localparam logic [31:0] I_BEQ     = 32'hFE20_8CE3; // beq  x1,x2,-8
    localparam logic [31:0] I_JAL     = 32'h0080_00EF; // jal  x1,8
    localparam logic [31:0] I_ADDI_X7 = 32'h0010_0393; // addi x7,x0,1
    localparam logic [31:0] I_BAD     = 32'hFFFF_FFFF;

    decode_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .rf_rs1        (rf_rs1),
        .rf_rs2        (rf_rs2),
        .rf_enable     (rf_enable),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_imm       (out_imm),
        .out_alu_op    (out_alu_op),
        .out_rf_we     (out_rf_we),
        .out_is_load   (out_is_load),
        .out_is_store  (out_is_store),
        .out_is_branch (out_is_branch),
        .out_is_jump   (out_is_jump),
        .out_illegal   (out_illegal),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        out_ready = 1'b0;
        cyc();
        reset = 1'b0;
        settle();
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        #2;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_rf_enable", 32'(rf_enable), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc",    out_pc,         32'd0);
        check("rst_pend",      dut.pend,       32'd0);
        do_reset();

        // ADDI x5,x0,7
        out_ready = 1'b1;
        present(I_ADDI_X5, 32'h100);
        settle();
        check("addi_in_ready",  32'(in_ready),  32'd1);
        check("addi_rf_enable", 32'(rf_enable), 32'd1);
        check("addi_rf_rs1",    32'(rf_rs1),    32'd0);
        cyc();
        check("addi_valid", 32'(out_valid),  32'd1);
        check("addi_rd",    32'(out_rd),     32'd5);
        check("addi_imm",   out_imm,         32'd7);
        check("addi_we",    32'(out_rf_we),  32'd1);
        check("addi_pc",    out_pc,          32'h100);
        check("addi_alu",   32'(out_alu_op), 32'd0);

        // ADD x6,x5,x5 stalls on held packet, then on pend[5]
        present(I_ADD_X6, 32'h104);
        settle();
        check("raw_held_stall", 32'(in_ready), 32'd0);
        cyc();
        check("raw_gap_valid", 32'(out_valid), 32'd0);
        check("raw_pend_stall", 32'(in_ready), 32'd0);
        check("raw_pend5",      dut.pend,      32'h20);
        cyc();
        check("raw_pend_stall2", 32'(in_ready), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd5;
        settle();
        check("raw_wb_bypass", 32'(in_ready), 32'd1);
        cyc();
        wb_valid = 1'b0;
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_rd",    32'(out_rd),    32'd6);
        check("add_pc",    out_pc,         32'h104);

        // Illegal word
        present(I_BAD, 32'h108);
        settle();
        check("bad_in_ready", 32'(in_ready), 32'd1);
        cyc();
        check("bad_illegal", 32'(out_illegal), 32'd1);
        check("bad_we",      32'(out_rf_we),   32'd0);
        check("bad_imm",     out_imm,          32'd0);
        in_valid = 1'b0;
        cyc();
        check("bad_pend", dut.pend, 32'h40);
        check("bad_drained", 32'(out_valid), 32'd0);

        // Backpressure: held packet stable for 3 cycles
        do_reset();
        present(I_SUB_X8, 32'h200);
        settle();
        check("sub_in_ready", 32'(in_ready), 32'd1);
        cyc();
        check("sub_valid", 32'(out_valid),  32'd1);
        check("sub_alu",   32'(out_alu_op), 32'd1);
        check("sub_rd",    32'(out_rd),     32'd8);
        present(I_LUI_X10, 32'h204);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            cyc();
            check("bp_pc",    out_pc,         32'h200);
            check("bp_rd",    32'(out_rd),    32'd8);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        settle();
        check("bp_release", 32'(in_ready), 32'd1);
        cyc();
        check("lui_rd",  32'(out_rd),     32'd10);
        check("lui_imm", out_imm,         32'h1234_5000);
        check("lui_alu", 32'(out_alu_op), 32'd10);
        check("lui_pc",  out_pc,          32'h204);

        // Back-to-back store / branch / jump
        present(I_SW, 32'h208);
        cyc();
        check("sw_store", 32'(out_is_store), 32'd1);
        check("sw_imm",   out_imm,           32'hFFFF_FFFC);
        check("sw_we",    32'(out_rf_we),    32'd0);
        present(I_BEQ, 32'h20C);
        cyc();
        check("beq_branch", 32'(out_is_branch), 32'd1);
        check("beq_imm",    out_imm,            32'hFFFF_FFF8);
        check("beq_alu",    32'(out_alu_op),    32'd1);
        present(I_JAL, 32'h210);
        cyc();
        check("jal_jump", 32'(out_is_jump), 32'd1);
        check("jal_imm",  out_imm,          32'd8);
        check("jal_we",   32'(out_rf_we),   32'd1);
        check("jal_rd",   32'(out_rd),      32'd1);
        in_valid = 1'b0;

        // Flush of a held packet writing x7
        do_reset();
        present(I_ADDI_X7, 32'h300);
        cyc();
        check("fl_held_valid", 32'(out_valid), 32'd1);
        check("fl_held_rd",    32'(out_rd),    32'd7);
        present(I_LUI_X10, 32'h304);
        out_ready = 1'b1;
        flush = 1'b1;
        settle();
        check("fl_in_ready",  32'(in_ready),  32'd0);
        check("fl_rf_enable", 32'(rf_enable), 32'd0);
        cyc();
        flush = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_pend",  dut.pend,       32'd0);
        present(I_SW, 32'h308);
        settle();
        check("fl_x7_free", 32'(in_ready), 32'd1);
        cyc();
        check("fl_sw_valid", 32'(out_valid),    32'd1);
        check("fl_sw_store", 32'(out_is_store), 32'd1);
        in_valid = 1'b0;

        // Reset while stalled on pend[5]
        do_reset();
        out_ready = 1'b1;
        present(I_ADDI_X5, 32'h400);
        cyc();
        present(I_ADD_X6, 32'h404);
        cyc();
        check("rs_pend_before", dut.pend,      32'h20);
        check("rs_stalled",     32'(in_ready), 32'd0);
        reset = 1'b1;
        settle();
        check("rs_pend_clr",  dut.pend,        32'd0);
        check("rs_valid_clr", 32'(out_valid),  32'd0);
        check("rs_in_ready",  32'(in_ready),   32'd0);
        check("rs_rf_enable", 32'(rf_enable),  32'd0);
        cyc();
        reset = 1'b0;
        settle();
        check("rs_released", 32'(in_ready), 32'd1);
        cyc();
        check("rs_add_valid", 32'(out_valid), 32'd1);
        check("rs_add_rd",    32'(out_rd),    32'd6);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage sitting directly upstream of the register file. Accepts fetched RV32I instructions over a valid/ready handshake and drives the register file read addresses and enable. Decodes fields, immediate and control, then presents a registered decode packet to execute, aligned with the register file's clocked operand outputs. A 32-entry pending-write scoreboard stalls issue on RAW hazards until writeback clears them.

## Interface
Parameters:
- XLEN, 32, datapath/instruction width
- NREG, 32, architectural register count (index width = 5)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- rf_rs1, rf_rs2  out  5 each  register file read addresses (combinational from in_instr)
- rf_enable  out  1  register file read enable = in_valid & in_ready
- out_valid  out  1  decode packet valid
- out_ready  in  1  execute accepts packet
- out_pc  out  32  registered PC
- out_rd  out  5  destination register
- out_imm  out  32  sign-extended immediate
- out_alu_op  out  4  ALU operation code
- out_rf_we, out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal  out  1 each  control flags
- wb_valid  in  1  writeback retiring a register write
- wb_rd  in  5  register being written back
- flush  in  1  squash held packet (branch redirect)

## Operation
- Decode purely from in_instr; opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode: out_illegal=1, out_rf_we=0, other flags 0.
- Immediates: I/S/B/U/J formats per RV32I, sign-extended from bit 31; U = {instr[31:12],12'b0}; B/J bit 0 = 0.
- rs1_used: all except LUI, AUIPC, JAL. rs2_used: BRANCH, STORE, OP.
- rf_we=1 only when rd≠0 and opcode in {LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP}.
- Scoreboard `pend[31:0]`: bit rd set on downstream handshake (out_valid & out_ready & out_rf_we); bit wb_rd cleared on wb_valid. Same-cycle set and clear of same bit: set wins. Bit 0 never set.
- Effective pending = pend & ~(wb_valid ? onehot(wb_rd) : 0) — writeback bypasses the check the same cycle.
- hazard = (rs1_used & rs≠0 & (eff_pend[rs1] | held match)) | same for rs2; held match = out_valid & out_rf_we & out_rd==rs.
- in_ready = ~reset & ~flush & ~hazard & (~out_valid | out_ready).
- On accept: packet registered, out_valid=1. Held packet stable while out_valid & ~out_ready.
- flush: out_valid→0 next edge, no scoreboard bit set for squashed packet, no accept that cycle; pend otherwise unchanged (in-flight writes still retire).

## Timing
- Reset: out_valid=0, all out_* =0, pend=0; in_ready=0 and rf_enable=0 while reset high.
- Latency: accept at edge N → out_valid and register file out1/out2 valid after edge N (same cycle).
- Throughput: one instruction/cycle with no hazards and out_ready=1.
- Hazard stall: in_ready low until writeback of the conflicting register; accept in the same cycle wb_valid matches.
- Reset mid-stall: all state cleared asynchronously; pending stall released.

## Structure
- Shared package: opcode constants, ALU op encoding (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB), immediate format enum.
- One sub-module: imm_gen (combinational immediate extraction by format).

## Test plan
- ADDI x5,x0,7 (0x00700293) valid, out_ready=1 -> next cycle out_valid=1, out_rd=5, out_imm=7, out_rf_we=1, rf_rs1=0.
- ADDI x5 issued, then ADD x6,x5,x5 -> in_ready=0 until wb_valid & wb_rd=5, accepted that same cycle.
- Illegal word 0xFFFFFFFF -> out_illegal=1, out_rf_we=0, no scoreboard bit set.
- out_ready=0 for 3 cycles with packet held -> out_* stable, in_ready=0; release -> next packet accepted.
- flush with held packet writing x7 -> out_valid=0 next cycle, pend[7]=0, subsequent read of x7 not stalled.
- Reset asserted while pend=0x00000020 and stalled -> pend=0, out_valid=0 immediately; after release, stalled instruction accepted.
